// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the N:1 arbitrated multiplexor.
package mux_arb_pkg;

    // Selection policy of the multiplexor.
    typedef enum logic [0:0] {
        MODE_SELECT = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_e;

    // Occupancy of the single-entry output stage.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_CHANNELS = 3;

    // Index that follows idx in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/multiplexor_n_1_arb_rr_arbiter.sv
// Round-robin search: first requesting channel at or after the pointer,
// wrapping modulo CHANNELS. Purely combinational.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    pointer,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] idx_s;

    // Walk the ring starting at the pointer; the first hit wins.
    always_comb begin
        grant       = {SEL_W{1'b0}};
        grant_valid = 1'b0;
        sum_s       = {(SEL_W+1){1'b0}};
        idx_s       = {SEL_W{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            sum_s = {1'b0, pointer} + (SEL_W+1)'(k);
            if (sum_s >= (SEL_W+1)'(CHANNELS)) begin
                sum_s = sum_s - (SEL_W+1)'(CHANNELS);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[SEL_W-1:0];
            if (!grant_valid && req[idx_s]) begin
                grant       = idx_s;
                grant_valid = 1'b1;
            end else begin
                grant       = grant;
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/multiplexor_n_1_arb.sv
// N:1 multiplexor with selector-driven or round-robin channel choice and a
// single registered output stage that sustains one word per cycle.
module multiplexor_n_1_arb
    import mux_arb_pkg::*;
#(
    parameter int        WIDTH    = DEFAULT_WIDTH,
    parameter int        CHANNELS = DEFAULT_CHANNELS,
    parameter mux_mode_e MODE     = MODE_SELECT,
    localparam int       SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] Data_In,
    input  logic [CHANNELS-1:0]       In_Valid,
    output logic [CHANNELS-1:0]       In_Ready,
    input  logic [SEL_W-1:0]          Selector,
    input  logic                      Enable,
    output logic [WIDTH-1:0]          Data_Out,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic [SEL_W-1:0]          Out_Channel,
    output logic [15:0]               Xfer_Count
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [15:0]      count_q, count_d;
    logic [SEL_W-1:0] pointer_q, pointer_d;

    logic             sel_in_range_s;
    logic [SEL_W-1:0] cand_s;
    logic             cand_valid_s;
    logic             stage_open_s;
    logic             accept_s;
    logic [SEL_W-1:0] rr_grant_s;
    logic             rr_grant_valid_s;

    // The round-robin search only exists when that policy is selected.
    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .CHANNELS (CHANNELS)
            ) u_rr_arbiter (
                .req         (In_Valid),
                .pointer     (pointer_q),
                .grant       (rr_grant_s),
                .grant_valid (rr_grant_valid_s)
            );
        end else begin : g_no_rr
            assign rr_grant_s       = {SEL_W{1'b0}};
            assign rr_grant_valid_s = 1'b0;
        end
    endgenerate

    // Candidate channel for this cycle under the configured policy.
    always_comb begin
        sel_in_range_s = (32'(Selector) < 32'(CHANNELS));
        cand_s         = {SEL_W{1'b0}};
        cand_valid_s   = 1'b0;
        if (MODE == MODE_RR) begin
            cand_s       = rr_grant_s;
            cand_valid_s = rr_grant_valid_s;
        end else begin
            cand_s = Selector;
            if (sel_in_range_s) begin
                cand_valid_s = In_Valid[Selector];
            end else begin
                cand_valid_s = 1'b0;
            end
        end
    end

    // FSM outputs: stage openness, accept decision and the one-hot accept strobe.
    always_comb begin
        stage_open_s = (state_q == EMPTY) || Out_Ready;
        accept_s     = Enable && cand_valid_s && stage_open_s && !reset;
        In_Ready     = {CHANNELS{1'b0}};
        if (accept_s) begin
            In_Ready[cand_s] = 1'b1;
        end else begin
            In_Ready = {CHANNELS{1'b0}};
        end
    end

    // FSM next state: a new word always lands FULL, a consume without one empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept_s) begin
                    state_d = FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (accept_s) begin
                    state_d = FULL;
                end else if (Out_Ready) begin
                    state_d = EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Datapath next values: load the chosen word and bump counter/pointer on accept.
    always_comb begin
        data_d    = data_q;
        chan_d    = chan_q;
        count_d   = count_q;
        pointer_d = pointer_q;
        if (accept_s) begin
            data_d  = Data_In[32'(cand_s)*WIDTH +: WIDTH];
            chan_d  = cand_s;
            count_d = count_q + 16'd1;
            if (MODE == MODE_RR) begin
                pointer_d = SEL_W'(wrap_inc(32'(cand_s), 32'(CHANNELS)));
            end else begin
                pointer_d = pointer_q;
            end
        end else begin
            data_d    = data_q;
            chan_d    = chan_q;
            count_d   = count_q;
            pointer_d = pointer_q;
        end
    end

    // State register; reset discards any held word immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            data_q    <= {WIDTH{1'b0}};
            chan_q    <= {SEL_W{1'b0}};
            count_q   <= 16'd0;
            pointer_q <= {SEL_W{1'b0}};
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            count_q   <= count_d;
            pointer_q <= pointer_d;
        end
    end

    assign Data_Out    = data_q;
    assign Out_Valid   = (state_q == FULL);
    assign Out_Channel = chan_q;
    assign Xfer_Count  = count_q;

endmodule

// File: tb/tb_multiplexor_n_1_arb.sv
// Scoreboard bench: one selector-mode and one round-robin instance share the
// same stimulus; a behavioural model predicts accepts, a monitor checks words.
module tb_multiplexor_n_1_arb;
    import mux_arb_pkg::*;

    localparam int W  = 16;
    localparam int CH = 3;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  ch;
        logic [15:0] cnt;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [47:0]   Data_In;
    logic [2:0]    In_Valid;
    logic [1:0]    Selector;
    logic          Enable;
    logic          Out_Ready;

    logic [2:0]    irdy [2];
    logic [15:0]   dout [2];
    logic          ovld [2];
    logic [1:0]    ochan [2];
    logic [15:0]   xcnt [2];

    int            tests_run;
    int            fails;

    bit            held [2];
    int            ptr;
    logic [15:0]   cnt [2];
    exp_t          q0 [$];
    exp_t          q1 [$];

    multiplexor_n_1_arb #(.WIDTH(W), .CHANNELS(CH), .MODE(MODE_SELECT)) u_sel (
        .clk(clk), .reset(reset), .Data_In(Data_In), .In_Valid(In_Valid),
        .In_Ready(irdy[0]), .Selector(Selector), .Enable(Enable),
        .Data_Out(dout[0]), .Out_Valid(ovld[0]), .Out_Ready(Out_Ready),
        .Out_Channel(ochan[0]), .Xfer_Count(xcnt[0])
    );

    multiplexor_n_1_arb #(.WIDTH(W), .CHANNELS(CH), .MODE(MODE_RR)) u_rr (
        .clk(clk), .reset(reset), .Data_In(Data_In), .In_Valid(In_Valid),
        .In_Ready(irdy[1]), .Selector(Selector), .Enable(Enable),
        .Data_Out(dout[1]), .Out_Valid(ovld[1]), .Out_Ready(Out_Ready),
        .Out_Channel(ochan[1]), .Xfer_Count(xcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level candidate rule: -1 means no candidate.
    function automatic int model_cand(input int d, input logic [2:0] vld, input logic [1:0] sel);
        if (d == 0) begin
            if (int'(sel) < CH && vld[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < CH; k++) begin
            if (vld[(ptr + k) % CH]) return (ptr + k) % CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            held[d] = 1'b0;
            cnt[d]  = 16'd0;
        end
        ptr = 0;
        q0.delete();
        q1.delete();
    endtask

    // Apply one cycle of stimulus, check combinational accept and occupancy,
    // and record the word the model expects to appear after the edge.
    task automatic cycle(input logic en, input logic [1:0] sel, input logic [2:0] vld,
                         input logic [47:0] din, input logic ordy);
        int   c;
        bit   acc;
        exp_t e;
        @(negedge clk);
        Enable = en; Selector = sel; In_Valid = vld; Data_In = din; Out_Ready = ordy;
        #1;
        for (int d = 0; d < 2; d++) begin
            c   = model_cand(d, vld, sel);
            acc = en && (c >= 0) && (!held[d] || ordy);
            check(d == 0 ? "sel_in_ready" : "rr_in_ready", 32'(irdy[d]),
                  acc ? (32'd1 << c) : 32'd0);
            check(d == 0 ? "sel_out_valid" : "rr_out_valid", 32'(ovld[d]), 32'(held[d]));
            if (acc) begin
                cnt[d] = cnt[d] + 16'd1;
                e.data = din[c*16 +: 16];
                e.ch   = 2'(c);
                e.cnt  = cnt[d];
                if (d == 0) q0.push_back(e); else q1.push_back(e);
                if (d == 1) ptr = (c + 1) % CH;
                held[d] = 1'b1;
            end else if (ordy) begin
                held[d] = 1'b0;
            end
        end
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    // Monitor: whenever a word is consumed, compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                for (int d = 0; d < 2; d++) begin
                    if (ovld[d] && Out_Ready) begin
                        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                            tests_run++;
                            fails++;
                            $display("FAIL unexpected_word dut%0d: got 0x%0h expected no word", d, dout[d]);
                        end else begin
                            e = (d == 0) ? q0.pop_front() : q1.pop_front();
                            check(d == 0 ? "sel_data" : "rr_data", 32'(dout[d]), 32'(e.data));
                            check(d == 0 ? "sel_chan" : "rr_chan", 32'(ochan[d]), 32'(e.ch));
                            check(d == 0 ? "sel_count" : "rr_count", 32'(xcnt[d]), 32'(e.cnt));
                        end
                    end
                end
            end
        end
    end

    initial begin
        tests_run = 0;
        fails     = 0;
        reset = 1'b1; Enable = 1'b0; Selector = 2'd0; In_Valid = 3'b000;
        Data_In = 48'd0; Out_Ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_data", 32'(dout[d]), 32'd0);
            check("rst_valid", 32'(ovld[d]), 32'd0);
            check("rst_chan", 32'(ochan[d]), 32'd0);
            check("rst_count", 32'(xcnt[d]), 32'd0);
        end

        // Round-robin over three always-valid channels: 0,1,2,0,1,2 with full throughput.
        repeat (6) cycle(1'b1, 2'(3'($urandom_range(0, 3))), 3'b111, rnd48(), 1'b1);
        check("rr_count_after6", 32'(cnt[1]), 32'd6);

        // Selector out of range: the selector instance must never accept.
        repeat (5) cycle(1'b1, 2'd3, 3'b111, rnd48(), 1'b1);

        // Single valid channel 1 carrying 0x1234, then four more words.
        cycle(1'b1, 2'd1, 3'b010, {16'h0000, 16'h1234, 16'h0000}, 1'b1);
        repeat (4) cycle(1'b1, 2'd1, 3'b010, rnd48(), 1'b1);
        cycle(1'b0, 2'd1, 3'b000, rnd48(), 1'b0);

        // Back-pressure: 0xAAAA held for four cycles, then replaced without a bubble.
        cycle(1'b1, 2'd0, 3'b001, {16'h0000, 16'h0000, 16'hAAAA}, 1'b1);
        repeat (4) cycle(1'b1, 2'd0, 3'b111, rnd48(), 1'b0);
        #1;
        for (int d = 0; d < 2; d++) check("hold_aaaa", 32'(dout[d]), 32'h0000AAAA);
        cycle(1'b1, 2'd2, 3'b100, rnd48(), 1'b1);

        // Enable low while FULL: the word drains and nothing new is accepted.
        cycle(1'b0, 2'd0, 3'b111, rnd48(), 1'b1);
        cycle(1'b0, 2'd0, 3'b111, rnd48(), 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
                  3'($urandom), rnd48(), ($urandom_range(0, 9) < 7));
        end

        // Drain, then build Xfer_Count=5 on a held word and reset between edges.
        repeat (3) cycle(1'b0, 2'd0, 3'b000, rnd48(), 1'b1);
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) cycle(1'b1, 2'd1, 3'b010, rnd48(), 1'b1);
        cycle(1'b0, 2'd1, 3'b010, rnd48(), 1'b0);
        @(negedge clk);
        Enable = 1'b1; In_Valid = 3'b111; Selector = 2'd0; Out_Ready = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("pre_rst_count", 32'(xcnt[d]), 32'd5);
            check("pre_rst_valid", 32'(ovld[d]), 32'd1);
        end
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("async_rst_valid", 32'(ovld[d]), 32'd0);
            check("async_rst_data", 32'(dout[d]), 32'd0);
            check("async_rst_count", 32'(xcnt[d]), 32'd0);
            check("async_rst_in_ready", 32'(irdy[d]), 32'd0);
        end
        model_reset();
        Enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        repeat (50) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 3'($urandom), rnd48(), ($urandom_range(0, 1) == 1));
        end
        repeat (3) cycle(1'b0, 2'd0, 3'b000, rnd48(), 1'b1);
        check("sel_queue_drained", 32'(q0.size()), 32'd0);
        check("rr_queue_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
